free_list: RTL
==============

Name: free_list

Overview:
- Physical-tag free list for the rename stage.
- Supplies up to 3 free 6-bit physical tags per cycle to rename for destination allocation.
- Accepts up to 3 released tags per cycle from retire/commit, where the previous mappings of committed destinations are freed.
- Circular FIFO of tags, the reclaim end of the remap-file protocol.

Parameters:
- NUM_PHYS, 64, number of physical registers; tag width is clog2(NUM_PHYS) = 6.
- NUM_ARCH, 15, architectural registers; tags 0..NUM_ARCH-1 are mapped at reset and never start free.
- WIDTH, 3, allocate/free lanes per cycle.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alloc_req_i  input  [2:0]  per-lane request for a destination tag.
- alloc_ok_o  output  1  all requested lanes granted this cycle.
- alloc_tags_o  output  [2:0][5:0]  tag per lane; meaningful only where alloc_req_i=1 and alloc_ok_o=1.
- free_valid_i  input  [2:0]  per-lane release valid.
- free_tags_i  input  [2:0][5:0]  tags being released.
- count_o  output  [6:0]  number of free tags held.
- err_o  output  1  sticky error flag.

Behaviour:
- Storage: NUM_PHYS-entry circular buffer of 6-bit tags; head (read) and tail (write) pointers are 6-bit and wrap modulo 64; 7-bit count.
- Reset (async assert, sync release on clk):
  - entries 0..48 hold tags 15..63;
  - head=0, tail=49, count=49, err_o=0.
  - Unused entries hold 0.
  - Reset asserted mid-operation discards all state immediately.
- Allocation is combinational on the read side.
  - n = popcount(alloc_req_i).
  - alloc_ok_o = (count >= n); it is 1 when n=0.
  - Requesting lane i receives entry[head + number of requesting lanes below i], so tags are packed in lane order. Example: mask 101 gives lane0=entry[head], lane2=entry[head+1].
  - Non-requesting lanes output 0.
  - All-or-nothing: if alloc_ok_o=0, no tag is consumed and head is unchanged.
  - On the clock edge with alloc_ok_o=1, head += n and count -= n.
- Free:
  - Valid lanes are compacted in lane order and written at tail, tail+1, ...
  - On the edge, tail += m and count += m, where m = popcount(free_valid_i).
- Simultaneous alloc and free in one cycle:
  - Allocation sees the pre-free count; freed tags are not bypassed to the same-cycle allocation.
  - Next count = count - (alloc_ok_o ? n : 0) + m.
- Overflow: if count - granted + m > NUM_PHYS, the whole free operation is dropped, err_o is set, and allocation still proceeds.
- err_o stays set until reset.
- No stall output; rename must hold its bundle while alloc_ok_o=0.

Optional Feature:
- Macro: FREE_LIST_DUP_CHECK_EN.
- With it:
  - A 64-bit free bitmap is kept; at reset, bits 15..63 are 1.
  - Allocation clears the bits of granted tags; free sets the bits of freed tags.
  - A free is illegal if its tag bit is already 1, its tag is < NUM_ARCH while never previously allocated, or two valid free lanes carry the same tag.
  - An illegal free drops that lane only; valid lanes are still compacted and written. The illegal free sets err_o.
- Without it: no bitmap, no per-tag checks; err_o reflects overflow only.

Decomposition:
- Shared package rename_pkg holds PHYS_TAG_W=6, NUM_PHYS_REGS=64, NUM_ARCH_REGS=15, RENAME_WIDTH=3, and typedef phys_tag_t.
- One sub-module, free_list_compact: 3-lane mask in, per-lane prefix offsets (0..2) and popcount out. It is instantiated twice, for the alloc and free sides.

Test Plan:
- Reset release, no requests: count_o=49, err_o=0; mask 111 gives alloc_ok_o=1 and tags 15,16,17; next cycle count_o=46.
- From reset, alloc mask 101: lane0=15, lane1=0, lane2=16, count 47; next mask 010 gives lane1=17.
- Drain to count=2, then mask 111 with free_valid 111 of tags {20,21,22} in the same cycle: alloc_ok_o=0, head unchanged, count 5; next mask 111 grants the old 2 heads then tag 20.
- Wrap-around: 40 cycles of alloc 3 + free 3 in lockstep with known tags; every granted tag sequence matches FIFO order across the 63→0 pointer wrap; count stays 49.
- Free 3 tags at count=63: overflow, count unchanged, err_o=1 and remains set; then rst_n low mid-cycle resets immediately to count=49 and err_o=0.
- With FREE_LIST_DUP_CHECK_EN defined, from reset free tag 30 (already free): lane dropped, count 49, err_o=1. Free lanes {40,40} after allocating 40: one write, err_o=1.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared rename-stage constants and types.
// Used by the physical-tag free list and its lane compaction helper.
package rename_pkg;

  localparam int PHYS_TAG_W    = 6;
  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 15;
  localparam int RENAME_WIDTH  = 3;

  localparam int COUNT_W    = PHYS_TAG_W + 1;
  localparam int LANE_CNT_W = 2;
  localparam int ARCH_IDX_W = $clog2(NUM_ARCH_REGS);

  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
  typedef logic [COUNT_W-1:0]    count_t;
  typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

  // Tags NUM_ARCH_REGS..NUM_PHYS_REGS-1 start out free.
  localparam int RESET_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;

endpackage

// File: rtl/free_list_compact.sv
// Lane compaction helper: per-lane prefix offsets and total popcount of a
// RENAME_WIDTH-bit mask, so active lanes pack in lane order.
module free_list_compact
  import rename_pkg::*;
(
  input  logic      [RENAME_WIDTH-1:0] mask,
  output lane_cnt_t [RENAME_WIDTH-1:0] offset,
  output lane_cnt_t                    total
);

  always_comb begin
    lane_cnt_t acc;
    // NOTE: combinational logic uses blocking '=' so the running sum is
    // visible to the next loop iteration in the same evaluation.
    acc = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      offset[i] = acc;
      acc       = acc + lane_cnt_t'(mask[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/free_list.sv
// Physical-tag free list: circular FIFO supplying up to three tags per cycle
// to rename and reclaiming up to three per cycle from commit.
// Optional duplicate/illegal-free checking: define FREE_LIST_DUP_CHECK_EN.
module free_list
  import rename_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [RENAME_WIDTH-1:0]                 alloc_req_i,
  output logic                                    alloc_ok_o,
  output logic [RENAME_WIDTH-1:0][PHYS_TAG_W-1:0] alloc_tags_o,
  input  logic [RENAME_WIDTH-1:0]                 free_valid_i,
  input  logic [RENAME_WIDTH-1:0][PHYS_TAG_W-1:0] free_tags_i,
  output logic [COUNT_W-1:0]                      count_o,
  output logic                                    err_o
);

  typedef logic [COUNT_W:0] wide_count_t;

  phys_tag_t entries [NUM_PHYS_REGS];
  phys_tag_t head;
  phys_tag_t tail;
  count_t    count;
  logic      err;

  lane_cnt_t [RENAME_WIDTH-1:0] alloc_off;
  lane_cnt_t [RENAME_WIDTH-1:0] free_off;
  lane_cnt_t                    alloc_n;
  lane_cnt_t                    free_m;
  lane_cnt_t                    granted;
  logic      [RENAME_WIDTH-1:0] free_keep;
  logic                         illegal_any;
  wide_count_t                  count_sum;
  logic                         overflow;

  free_list_compact u_alloc_compact (
    .mask   (alloc_req_i),
    .offset (alloc_off),
    .total  (alloc_n)
  );

  free_list_compact u_free_compact (
    .mask   (free_keep),
    .offset (free_off),
    .total  (free_m)
  );

  // Read side is purely combinational; freed tags are never bypassed.
  always_comb begin
    alloc_ok_o = (count >= count_t'(alloc_n));
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      alloc_tags_o[i] = alloc_req_i[i] ? entries[head + phys_tag_t'(alloc_off[i])] : '0;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    granted   = '0;
    if (alloc_ok_o) granted = alloc_n;
    count_sum = wide_count_t'(count) - wide_count_t'(granted) + wide_count_t'(free_m);
    overflow  = (count_sum > wide_count_t'(NUM_PHYS_REGS));
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [NUM_PHYS_REGS-1:0] free_map;
  logic [NUM_ARCH_REGS-1:0] arch_seen;
  logic [RENAME_WIDTH-1:0]  legal;

  localparam logic [NUM_PHYS_REGS-1:0] RESET_FREE_MAP =
    ~((NUM_PHYS_REGS'(1) << NUM_ARCH_REGS) - NUM_PHYS_REGS'(1));

  // A later lane repeating an earlier valid lane's tag is the one dropped.
  always_comb begin
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      legal[i] = 1'b1;
      if (free_map[free_tags_i[i]]) legal[i] = 1'b0;
      if (free_tags_i[i] < phys_tag_t'(NUM_ARCH_REGS) &&
          !arch_seen[free_tags_i[i][ARCH_IDX_W-1:0]]) legal[i] = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (free_valid_i[j] && free_tags_i[j] == free_tags_i[i]) legal[i] = 1'b0;
      end
    end
    free_keep   = free_valid_i & legal;
    illegal_any = |(free_valid_i & ~legal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_map  <= RESET_FREE_MAP;
      arch_seen <= '0;
    end else begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
        if (alloc_ok_o && alloc_req_i[i]) begin
          free_map[alloc_tags_o[i]] <= 1'b0;
          if (alloc_tags_o[i] < phys_tag_t'(NUM_ARCH_REGS))
            arch_seen[alloc_tags_o[i][ARCH_IDX_W-1:0]] <= 1'b1;
        end
      end
      // A granted tag's bit was 1 and a kept free's bit was 0, so these never collide.
      if (!overflow) begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
          if (free_keep[i]) free_map[free_tags_i[i]] <= 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    free_keep   = free_valid_i;
    illegal_any = 1'b0;
  end
`endif

  // NOTE: the tag array is reset too, because the initial free tags must be
  // present the moment reset releases; this costs flops, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        entries[i] <= (i < RESET_FREE) ? phys_tag_t'(i + NUM_ARCH_REGS) : '0;
      end
      head  <= '0;
      tail  <= phys_tag_t'(RESET_FREE);
      count <= count_t'(RESET_FREE);
      err   <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking '<=' so every register samples
      // the pre-edge values regardless of statement order.
      head <= head + phys_tag_t'(granted);
      if (overflow) begin
        count <= count - count_t'(granted);
      end else begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
          if (free_keep[i]) entries[tail + phys_tag_t'(free_off[i])] <= free_tags_i[i];
        end
        tail  <= tail + phys_tag_t'(free_m);
        count <= count_t'(count_sum);
      end
      err <= err | overflow | illegal_any;
    end
  end

  assign count_o = count;
  assign err_o   = err;

endmodule
